// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle for the bit-serial adder.
// The master side issues operations; the slave side is the adder.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             co;

  modport master (
    output start, a, b, ci,
    input  busy, done, sum, co
  );

  modport slave (
    input  start, a, b, ci,
    output busy, done, sum, co
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop,
// LSB first, one bit pair per clock, parallel result with a done pulse.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] s_sh_q, s_sh_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             co_q, co_d;

  logic             fa_s, fa_co;
  logic [WIDTH-1:0] s_shift;

  full_adder u_fa (
    .a  (a_sh_q[0]),
    .b  (b_sh_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    s_sh_d  = s_sh_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    co_d    = co_q;
    // New sum bit enters at the MSB; written this way so WIDTH=1 needs no special case.
    s_shift            = s_sh_q >> 1;
    s_shift[WIDTH-1]   = fa_s;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          carry_d = bus.ci;
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        s_sh_d  = s_shift;
        carry_d = fa_co;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          sum_d   = s_shift;
          co_d    = fa_co;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      co_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      s_sh_q  <= s_sh_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
    end
  end

  assign bus.busy = (state_q == SHIFT);
  assign bus.done = (state_q == DONE);
  assign bus.sum  = sum_q;
  assign bus.co   = co_q;
endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder at WIDTH=8, plus WIDTH=1 and WIDTH=13
// scoreboards, with a per-cycle monitor on done/busy exclusivity and result stability.
module tb_serial_adder;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rst_x_n = 1'b0;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8))  bus8 ();
  serial_adder_if #(.WIDTH(1))  bus1 ();
  serial_adder_if #(.WIDTH(13)) bus13 ();

  serial_adder #(.WIDTH(8))  dut   (.clk(clk), .rst_n(rst_n),   .bus(bus8));
  serial_adder #(.WIDTH(1))  dut1  (.clk(clk), .rst_n(rst_x_n), .bus(bus1));
  serial_adder #(.WIDTH(13)) dut13 (.clk(clk), .rst_n(rst_x_n), .bus(bus13));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Always-on monitor for the WIDTH=8 instance
  logic [8:0] prev_out;
  logic       prev_done;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_out  <= {bus8.co, bus8.sum};
      prev_done <= 1'b0;
    end else begin
      chk("mon_onehot", 64'(bus8.busy & bus8.done), 64'd0);
      chk("mon_dbl_done", 64'(prev_done & bus8.done), 64'd0);
      if (!bus8.done) chk("mon_hold", 64'({bus8.co, bus8.sum}), 64'(prev_out));
      prev_out  <= {bus8.co, bus8.sum};
      prev_done <= bus8.done;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic run_op(input logic [7:0] oa, input logic [7:0] ob, input logic oci,
                        input logic [7:0] es, input logic eco, input string tag);
    int n;
    @(posedge clk); #1;
    bus8.start = 1'b1; bus8.a = oa; bus8.b = ob; bus8.ci = oci;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    chk({tag, "_busy"}, 64'(bus8.busy), 64'd1);
    n = 0;
    while (!bus8.done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'd8);
    chk({tag, "_sum"}, 64'(bus8.sum), 64'(es));
    chk({tag, "_co"},  64'(bus8.co),  64'(eco));
  endtask

  task automatic rand_w1(input int cnt);
    logic oa, ob, oci;
    int n;
    for (int i = 0; i < cnt; i++) begin
      oa = 1'($urandom_range(0, 1)); ob = 1'($urandom_range(0, 1)); oci = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      bus1.start = 1'b1; bus1.a = oa; bus1.b = ob; bus1.ci = oci;
      @(posedge clk); #1;
      bus1.start = 1'b0;
      n = 0;
      while (!bus1.done && n < 10) begin
        @(posedge clk); #1;
        n++;
      end
      chk("w1_lat", 64'(n), 64'd1);
      chk("w1_res", 64'({bus1.co, bus1.sum}), 64'(oa) + 64'(ob) + 64'(oci));
    end
  endtask

  task automatic rand_w13(input int cnt);
    logic [12:0] oa, ob;
    logic        oci;
    int n;
    for (int i = 0; i < cnt; i++) begin
      oa = 13'($urandom); ob = 13'($urandom); oci = 1'($urandom_range(0, 1));
      if (i == 0) begin oa = 13'h1FFF; ob = 13'h1FFF; oci = 1'b1; end
      @(posedge clk); #1;
      bus13.start = 1'b1; bus13.a = oa; bus13.b = ob; bus13.ci = oci;
      @(posedge clk); #1;
      bus13.start = 1'b0;
      n = 0;
      while (!bus13.done && n < 40) begin
        @(posedge clk); #1;
        n++;
      end
      chk("w13_lat", 64'(n), 64'd13);
      chk("w13_res", 64'({bus13.co, bus13.sum}), 64'(oa) + 64'(ob) + 64'(oci));
    end
  endtask

  int          dn, lastk, n;
  logic [7:0]  ra, rb;
  logic        rci;
  logic [8:0]  rexp;

  initial begin
    bus8.start = 1'b0;  bus8.a = '0;  bus8.b = '0;  bus8.ci = 1'b0;
    bus1.start = 1'b0;  bus1.a = '0;  bus1.b = '0;  bus1.ci = 1'b0;
    bus13.start = 1'b0; bus13.a = '0; bus13.b = '0; bus13.ci = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(bus8.busy), 64'd0);
    chk("rst_done", 64'(bus8.done), 64'd0);
    chk("rst_sum",  64'(bus8.sum),  64'd0);
    chk("rst_co",   64'(bus8.co),   64'd0);
    chk("rst_w13",  64'({bus13.co, bus13.sum, bus13.busy, bus13.done}), 64'd0);
    rst_n = 1'b1;
    rst_x_n = 1'b1;

    run_op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, "t1");
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "t2");
    run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "t3a");
    run_op(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, "t3b");

    // Second start mid-operation, with different operands, must be ignored
    @(posedge clk); #1;
    bus8.start = 1'b1; bus8.a = 8'h11; bus8.b = 8'h22; bus8.ci = 1'b0;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    dn = 0;
    for (int k = 0; k < 16; k++) begin
      if (bus8.done) begin
        dn++;
        chk("t4_sum", 64'(bus8.sum), 64'h33);
        chk("t4_co",  64'(bus8.co),  64'd0);
        chk("t4_k",   64'(k),        64'd8);
      end
      bus8.start = (k == 4);
      if (k == 4) begin bus8.a = 8'hFF; bus8.b = 8'hFF; bus8.ci = 1'b1; end
      @(posedge clk); #1;
    end
    chk("t4_ndone", 64'(dn), 64'd1);

    // Back-to-back operations with start held high
    bus8.start = 1'b1; bus8.a = 8'h01; bus8.b = 8'h01; bus8.ci = 1'b0;
    @(posedge clk); #1;
    dn = 0;
    lastk = -1;
    for (int k = 0; k < 27; k++) begin
      chk("t5_busy", 64'(bus8.busy), 64'(!bus8.done));
      if (bus8.done) begin
        dn++;
        chk("t5_sum", 64'({bus8.co, bus8.sum}), 64'h002);
        if (lastk >= 0) chk("t5_gap", 64'(k - lastk), 64'd9);
        lastk = k;
      end
      @(posedge clk); #1;
    end
    chk("t5_ndone", 64'(dn), 64'd3);
    bus8.start = 1'b0;
    n = 0;
    while ((bus8.busy || bus8.done) && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t5_drain", 64'(n < 30), 64'd1);

    // Reset in the middle of an operation aborts it silently
    @(posedge clk); #1;
    bus8.start = 1'b1; bus8.a = 8'h80; bus8.b = 8'h80; bus8.ci = 1'b0;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_busy", 64'(bus8.busy), 64'd0);
    chk("t6_done", 64'(bus8.done), 64'd0);
    chk("t6_sum",  64'(bus8.sum),  64'd0);
    chk("t6_co",   64'(bus8.co),   64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    dn = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus8.done) dn++;
    end
    chk("t6_nodone", 64'(dn), 64'd0);
    run_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, "t6b");

    for (int i = 0; i < 4; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rci = 1'($urandom_range(0, 1));
      rexp = 9'(ra) + 9'(rb) + 9'(rci);
      run_op(ra, rb, rci, rexp[7:0], rexp[8], "w8_rand");
    end

    rand_w1(6);
    rand_w13(6);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
